// File: rtl/fractal_stream_if.sv
// ----------------------------------------------------------------------------
// fractal_stream_if
//   AXI4-Stream video bus carrying one escape-count pixel per beat.
//   tuser marks the first pixel of a frame, tlast the last pixel of a line.
//
//   Parameter
//     TDATA_WIDTH  pixel width in bits (multiple of 8)
//   Signals
//     tvalid  master -> slave  pixel valid
//     tdata   master -> slave  pixel value
//     tstrb   master -> slave  byte strobes (all ones)
//     tuser   master -> slave  start of frame
//     tlast   master -> slave  end of line
//     tready  slave  -> master sink ready
// ----------------------------------------------------------------------------
interface fractal_stream_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                     tvalid;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic                     tuser;
    logic                     tlast;
    logic                     tready;

    modport master (
        output tvalid, tdata, tstrb, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tuser, tlast,
        output tready
    );
endinterface

// File: rtl/fractal_stream_gen.sv
// ----------------------------------------------------------------------------
// fractal_stream_gen
//   Mandelbrot pixel engine. Raster-scans a WIDTH x HEIGHT frame, runs one
//   z = z^2 + c iteration per clock and emits the escape count of each pixel
//   as one AXI4-Stream beat. Frames run back-to-back while cfg_enable is high;
//   configuration is captured only at frame start.
//
//   Ports
//     aclk, aresetn        clock, synchronous active-low reset
//     cfg_enable           run frames while high
//     cfg_x0, cfg_y0       c at pixel (0,0), signed fixed point
//     cfg_dx, cfg_dy       c step per column / per row, signed fixed point
//     cfg_max_iter         iteration limit (0 behaves as 1)
//     busy                 frame in progress
//     frame_count          completed frames, wrapping
//     irq                  one-cycle pulse after the last pixel of a frame
//                          (present only with FRACTAL_FRAME_IRQ_EN defined)
//     m_axis               pixel stream master (tuser = SOF, tlast = EOL)
//
//   Optional feature macro: FRACTAL_FRAME_IRQ_EN
// ----------------------------------------------------------------------------
module fractal_stream_gen #(
    parameter int WIDTH              = 640,
    parameter int HEIGHT             = 480,
    parameter int COORD_WIDTH        = 32,
    parameter int FRAC_BITS          = 28,
    parameter int ITER_WIDTH         = 8,
    parameter int M_AXIS_TDATA_WIDTH = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cfg_enable,
    input  logic signed [COORD_WIDTH-1:0] cfg_x0,
    input  logic signed [COORD_WIDTH-1:0] cfg_y0,
    input  logic signed [COORD_WIDTH-1:0] cfg_dx,
    input  logic signed [COORD_WIDTH-1:0] cfg_dy,
    input  logic [ITER_WIDTH-1:0]         cfg_max_iter,
    output logic                          busy,
    output logic [15:0]                   frame_count,
`ifdef FRACTAL_FRAME_IRQ_EN
    output logic                          irq,
`endif
    fractal_stream_if.master              m_axis
);

    localparam int CW    = COORD_WIDTH;
    localparam int PW    = 2 * COORD_WIDTH;
    localparam int TW    = M_AXIS_TDATA_WIDTH;
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    // |z|^2 bound of 4.0 expressed in product scaling (2*FRAC_BITS fraction bits).
    localparam logic [PW:0]      ESC_LIMIT = (PW + 1)'(4) << (2 * FRAC_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    // Per-frame configuration shadows
    logic signed [CW-1:0]  sh_x0, sh_dx, sh_dy;
    logic [ITER_WIDTH-1:0] sh_max_iter;

    // Pixel position, current c and iteration state
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic signed [CW-1:0]  cr, ci, zr, zi;
    logic [ITER_WIDTH-1:0] n;

    // Iteration datapath
    logic signed [PW-1:0]  zr_ext, zi_ext, rr, ii, ri, diff;
    logic [PW:0]           mag;
    logic signed [CW-1:0]  zr_nxt, zi_nxt;
    logic                  escape;

    logic                  hs, last_col, last_pix, start_frame;

    // NOTE: combinational blocks assign every output a default first so no
    // path through them leaves a value held, which would infer a latch.
    always_comb begin
        zr_ext = {{CW{zr[CW-1]}}, zr};
        zi_ext = {{CW{zi[CW-1]}}, zi};
        rr     = zr_ext * zr_ext;
        ii     = zi_ext * zi_ext;
        ri     = zr_ext * zi_ext;
        // Both squares are non-negative, so an unsigned sum one bit wider cannot overflow.
        mag    = {1'b0, rr} + {1'b0, ii};
        escape = (n == sh_max_iter) || (mag > ESC_LIMIT);
        diff   = rr - ii;
        zr_nxt = CW'(diff >>> FRAC_BITS) + cr;
        // Shifting by one bit less than the fraction doubles zr*zi.
        zi_nxt = CW'(ri >>> (FRAC_BITS - 1)) + ci;
    end

    assign hs          = (state == S_OUT) && m_axis.tready;
    assign last_col    = (col == COL_LAST);
    assign last_pix    = last_col && (row == ROW_LAST);
    assign start_frame = ((state == S_IDLE) && cfg_enable) || (hs && last_pix && cfg_enable);

    // ---------------------------------------------------------------- state register
    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (cfg_enable) state_nxt = S_INIT;
            S_INIT: state_nxt = S_ITER;
            S_ITER: if (escape) state_nxt = S_OUT;
            S_OUT: begin
                if (hs) begin
                    state_nxt = (last_pix && !cfg_enable) ? S_IDLE : S_INIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tuser  = 1'b0;
        m_axis.tlast  = 1'b0;
        m_axis.tstrb  = '1;
        busy          = (state != S_IDLE);
        if (state == S_OUT) begin
            m_axis.tvalid = 1'b1;
            // Zero-extend or truncate the count to the pixel width.
            m_axis.tdata  = TW'({{TW{1'b0}}, n});
            m_axis.tuser  = (row == '0) && (col == '0);
            m_axis.tlast  = last_col;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sh_x0       <= '0;
            sh_dx       <= '0;
            sh_dy       <= '0;
            sh_max_iter <= '0;
            col         <= '0;
            row         <= '0;
            cr          <= '0;
            ci          <= '0;
            zr          <= '0;
            zi          <= '0;
            n           <= '0;
            frame_count <= '0;
        end else begin
            if (start_frame) begin
                sh_x0       <= cfg_x0;
                sh_dx       <= cfg_dx;
                sh_dy       <= cfg_dy;
                sh_max_iter <= (cfg_max_iter == '0) ? ITER_WIDTH'(1) : cfg_max_iter;
                col         <= '0;
                row         <= '0;
                cr          <= cfg_x0;
                ci          <= cfg_y0;
            end else if (hs) begin
                if (last_col) begin
                    col <= '0;
                    cr  <= sh_x0;
                    row <= row + ROW_W'(1);
                    ci  <= ci + sh_dy;
                end else begin
                    col <= col + COL_W'(1);
                    cr  <= cr + sh_dx;
                end
            end

            if (hs && last_pix) begin
                frame_count <= frame_count + 16'd1;
            end

            if (state == S_INIT) begin
                zr <= '0;
                zi <= '0;
                n  <= '0;
            end else if ((state == S_ITER) && !escape) begin
                zr <= zr_nxt;
                zi <= zi_nxt;
                n  <= n + ITER_WIDTH'(1);
            end
        end
    end

`ifdef FRACTAL_FRAME_IRQ_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            irq <= 1'b0;
        end else begin
            irq <= hs && last_pix;
        end
    end
`endif

endmodule

// File: tb/tb_fractal_stream_gen.sv
// ----------------------------------------------------------------------------
// tb_fractal_stream_gen
//   Directed bench for fractal_stream_gen at WIDTH=4, HEIGHT=2, Q4.28.
//   Expected pixels come from a plain-arithmetic Mandelbrot model pushed into
//   a queue per frame; one negedge process compares every handshake, checks
//   that stalled beats hold steady and (when built with FRACTAL_FRAME_IRQ_EN)
//   that irq follows each end of frame by exactly one cycle.
// ----------------------------------------------------------------------------
module tb_fractal_stream_gen;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int CW   = 32;
    localparam int FB   = 28;
    localparam int IW   = 8;
    localparam int TW   = 8;
    localparam int NPIX = W * H;

    typedef struct {
        logic [TW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    logic                 aclk;
    logic                 aresetn;
    logic                 cfg_enable;
    logic signed [CW-1:0] cfg_x0, cfg_y0, cfg_dx, cfg_dy;
    logic [IW-1:0]        cfg_max_iter;
    logic                 busy;
    logic [15:0]          frame_count;
`ifdef FRACTAL_FRAME_IRQ_EN
    logic                 irq;
    int                   irq_count = 0;
`endif

    fractal_stream_if #(.TDATA_WIDTH(TW)) axis ();

    fractal_stream_gen #(
        .WIDTH(W), .HEIGHT(H), .COORD_WIDTH(CW), .FRAC_BITS(FB),
        .ITER_WIDTH(IW), .M_AXIS_TDATA_WIDTH(TW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_enable   (cfg_enable),
        .cfg_x0       (cfg_x0),
        .cfg_y0       (cfg_y0),
        .cfg_dx       (cfg_dx),
        .cfg_dy       (cfg_dy),
        .cfg_max_iter (cfg_max_iter),
        .busy         (busy),
        .frame_count  (frame_count),
`ifdef FRACTAL_FRAME_IRQ_EN
        .irq          (irq),
`endif
        .m_axis       (axis)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int    tests_run   = 0;
    int    fails       = 0;
    int    beat_idx    = 0;
    int    total_beats = 0;
    int    rdy_mode    = 0;  // 0: always ready, 1: toggle + stall on beat 2, 2: stall on beat 5
    beat_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    function automatic logic signed [127:0] wrap32(input logic signed [127:0] v);
        logic signed [31:0]  t;
        logic signed [127:0] r;
        t = v[31:0];
        r = t;
        return r;
    endfunction

    function automatic int unsigned mandel(input logic signed [31:0] cx,
                                           input logic signed [31:0] cy,
                                           input int unsigned mi);
        logic signed [127:0] zr, zi, rr, ii, ri, lim;
        int unsigned         lim_it;
        lim_it = (mi == 0) ? 1 : mi;
        lim    = 128'sd4 <<< (2 * FB);
        zr     = 0;
        zi     = 0;
        for (int unsigned k = 0; k <= lim_it; k++) begin
            rr = zr * zr;
            ii = zi * zi;
            ri = zr * zi;
            if (k == lim_it || (rr + ii) > lim) return k;
            zr = wrap32(((rr - ii) >>> FB) + cx);
            zi = wrap32(((2 * ri) >>> FB) + cy);
        end
        return lim_it;
    endfunction

    task automatic push_frame(input logic [31:0] x0, input logic [31:0] y0,
                              input logic [31:0] dx, input logic [31:0] dy,
                              input int unsigned mi);
        beat_t       b;
        logic [31:0] x, y;
        int unsigned cnt;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                x      = x0 + dx * 32'(c);
                y      = y0 + dy * 32'(r);
                cnt    = mandel(x, y, mi);
                b.data = cnt[TW-1:0];
                b.user = (r == 0) && (c == 0);
                b.last = (c == W - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // ------------------------------------------------------------ sink ready driver
    initial begin : ready_drv
        int  stall_left;
        bit  stall_done;
        stall_left   = 0;
        stall_done   = 0;
        axis.tready  = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                1: begin
                    if (beat_idx == 2 && axis.tvalid && !stall_done) begin
                        stall_left = 5;
                        stall_done = 1;
                    end
                    if (stall_left > 0) begin
                        axis.tready = 1'b0;
                        stall_left--;
                    end else begin
                        axis.tready = ~axis.tready;
                    end
                end
                2: axis.tready = (beat_idx != 5);
                default: begin
                    axis.tready = 1'b1;
                    stall_done  = 0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ compare process
    initial begin : compare
        bit    stalled;
        bit    prev_eof;
        beat_t held, e;
        stalled  = 0;
        prev_eof = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stalled  = 0;
                prev_eof = 0;
                beat_idx = 0;
            end else begin
`ifdef FRACTAL_FRAME_IRQ_EN
                if (irq || prev_eof) begin
                    check("irq_after_eof", irq, prev_eof);
                    if (irq) irq_count++;
                end
`endif
                prev_eof = 0;
                if (stalled) begin
                    check("hold_tvalid", axis.tvalid, 1'b1);
                    check("hold_tdata", axis.tdata, held.data);
                    check("hold_tuser", axis.tuser, held.user);
                    check("hold_tlast", axis.tlast, held.last);
                end
                if (axis.tvalid && axis.tready) begin
                    check("busy_on_beat", busy, 1'b1);
                    check("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("tdata", axis.tdata, e.data);
                        check("tuser", axis.tuser, e.user);
                        check("tlast", axis.tlast, e.last);
                    end
                    prev_eof = (beat_idx == NPIX - 1);
                    beat_idx = prev_eof ? 0 : beat_idx + 1;
                    total_beats++;
                end
                stalled   = axis.tvalid && !axis.tready;
                held.data = axis.tdata;
                held.user = axis.tuser;
                held.last = axis.tlast;
            end
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn    = 1'b0;
        cfg_enable = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic set_cfg(input logic [31:0] x0, input logic [31:0] y0,
                           input logic [31:0] dx, input logic [31:0] dy,
                           input logic [IW-1:0] mi);
        cfg_x0       = x0;
        cfg_y0       = y0;
        cfg_dx       = dx;
        cfg_dy       = dy;
        cfg_max_iter = mi;
    endtask

    task automatic pulse_enable();
        @(posedge aclk);
        #1;
        cfg_enable = 1'b1;
        @(posedge aclk);
        #1;
        cfg_enable = 1'b0;
    endtask

    task automatic wait_fc(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (frame_count != 16'(target) && k < budget) begin
            @(negedge aclk);
            k++;
        end
        check(name, frame_count, 16'(target));
    endtask

    task automatic check_idle(input string name);
        int hits;
        hits = 0;
        repeat (3) @(negedge aclk);
        check({name, "_busy"}, busy, 1'b0);
        repeat (20) begin
            @(negedge aclk);
            if (axis.tvalid) hits++;
        end
        check({name, "_no_tvalid"}, hits, 0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic run_one_frame(input logic [31:0] x0, input logic [31:0] y0,
                                 input logic [31:0] dx, input logic [31:0] dy,
                                 input logic [IW-1:0] mi, input string name);
        do_reset();
        set_cfg(x0, y0, dx, dy, mi);
        push_frame(x0, y0, dx, dy, mi);
        total_beats = 0;
        pulse_enable();
        wait_fc(1, 2000, {name, "_frame_count"});
        check_idle(name);
        check({name, "_beats"}, total_beats, NPIX);
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        aresetn    = 1'b0;
        cfg_enable = 1'b0;
        set_cfg(32'h0, 32'h0, 32'h0, 32'h0, 8'd16);
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", axis.tvalid, 1'b0);
        check("rst_tdata", axis.tdata, '0);
        check("rst_tuser", axis.tuser, 1'b0);
        check("rst_tlast", axis.tlast, 1'b0);
        check("rst_tstrb", axis.tstrb, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        aresetn = 1'b1;

        // Model pinned to hand-derived escape counts
        check("model_c0", mandel(32'h0000_0000, 0, 16), 16);
        check("model_c2", mandel(32'h2000_0000, 0, 16), 2);
        check("model_c3", mandel(32'h3000_0000, 0, 16), 1);
        check("model_cm2", mandel(32'hE000_0000, 0, 16), 16);
        check("model_mi0", mandel(32'h5000_0000, 0, 0), 1);

        // 1) c = 0 everywhere: every pixel saturates at max_iter
        run_one_frame(32'h0, 32'h0, 32'h0, 32'h0, 8'd16, "t1_zero");

        // 2) escape values
        run_one_frame(32'h2000_0000, 32'h0, 32'h1000_0000, 32'h0, 8'd16, "t2_escape");
        run_one_frame(32'hE000_0000, 32'h0, 32'h0, 32'h0, 8'd16, "t2_minus2");
        run_one_frame(32'hE000_0000, 32'hF800_0000, 32'h0800_0000, 32'h0800_0000, 8'd20, "t2_mixed");
        run_one_frame(32'h5000_0000, 32'h0, 32'h0, 32'h0, 8'd0, "t2_mi0");

        // 3) backpressure: toggling ready plus a 5-cycle stall on beat 2
        rdy_mode = 1;
        run_one_frame(32'h2000_0000, 32'h0, 32'h1000_0000, 32'h0, 8'd16, "t3_bp");
        rdy_mode = 0;

        // 4) enable held: three frames, new config seen only from frame 3,
        //    enable dropped on beat 3 of frame 3
        do_reset();
`ifdef FRACTAL_FRAME_IRQ_EN
        irq_count = 0;
`endif
        set_cfg(32'h2000_0000, 32'h0, 32'h1000_0000, 32'h0, 8'd16);
        push_frame(32'h2000_0000, 32'h0, 32'h1000_0000, 32'h0, 16);
        push_frame(32'h2000_0000, 32'h0, 32'h1000_0000, 32'h0, 16);
        @(posedge aclk);
        #1;
        cfg_enable = 1'b1;
        wait_fc(1, 2000, "t4_fc1");
        set_cfg(32'hE000_0000, 32'hF800_0000, 32'h0800_0000, 32'h0800_0000, 8'd12);
        push_frame(32'hE000_0000, 32'hF800_0000, 32'h0800_0000, 32'h0800_0000, 12);
        wait_fc(2, 2000, "t4_fc2");
        begin
            int k;
            k = 0;
            while (beat_idx != 3 && k < 2000) begin
                @(negedge aclk);
                k++;
            end
            check("t4_reach_beat3", beat_idx, 3);
        end
        cfg_enable = 1'b0;
        wait_fc(3, 2000, "t4_fc3");
        check_idle("t4");
`ifdef FRACTAL_FRAME_IRQ_EN
        check("t4_irq_pulses", irq_count, 3);
`endif

        // 5) reset while beat 5 is stalled, then restart cleanly
        do_reset();
        set_cfg(32'h2000_0000, 32'h0, 32'h1000_0000, 32'h0, 8'd16);
        push_frame(32'h2000_0000, 32'h0, 32'h1000_0000, 32'h0, 16);
        rdy_mode = 2;
        pulse_enable();
        begin
            int k;
            k = 0;
            while (!(beat_idx == 5 && axis.tvalid) && k < 2000) begin
                @(negedge aclk);
                k++;
            end
            check("t5_reach_beat5", beat_idx, 5);
        end
        repeat (2) @(negedge aclk);
        @(posedge aclk);
        #1;
        aresetn  = 1'b0;
        rdy_mode = 0;
        exp_q.delete();
        @(posedge aclk);
        #1;
        check("t5_rst_tvalid", axis.tvalid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_frame_count", frame_count, 16'd0);
        aresetn = 1'b1;
        push_frame(32'h2000_0000, 32'h0, 32'h1000_0000, 32'h0, 16);
        pulse_enable();
        wait_fc(1, 2000, "t5_restart_fc");
        check_idle("t5");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", tests_run);
        $fatal(1, "watchdog expired");
    end

endmodule
